// File: rtl/fp_pkg.sv
// Shared IEEE-754 field geometry and the per-operand classification struct
// used by the FPU front end (single and double precision only).
package fp_pkg;

    // Fraction field width: 23 for binary32, 52 for binary64.
    function automatic int fp_frac_bits(input int w);
        return (w == 64) ? 52 : 23;
    endfunction

    // Exponent field width: 8 for binary32, 11 for binary64.
    function automatic int fp_exp_bits(input int w);
        return (w == 64) ? 11 : 8;
    endfunction

    // At most one member is set; all clear means a normal number.
    typedef struct packed {
        logic nan;
        logic inf;
        logic denorm;
        logic zero;
    } fp_class_t;

endpackage

// File: rtl/fp_classify_one.sv
// Classifies a single raw IEEE-754 operand into NaN / infinity / subnormal /
// zero. The sign bit plays no part in the classification.
module fp_classify_one
    import fp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    output fp_class_t    cls
);

    localparam int F = fp_frac_bits(W);
    localparam int E = fp_exp_bits(W);

    generate
        if (W != 32 && W != 64) begin : g_bad_width
            $error("fp_classify_one: W must be 32 or 64, got %0d", W);
        end
    endgenerate

    logic [E-1:0] exp_field;
    logic [F-1:0] mant_field;
    logic         exp_ones;
    logic         exp_zero;
    logic         mant_zero;
    logic         unused_sign;

    assign exp_field   = x[W-2:F];
    assign mant_field  = x[F-1:0];
    assign unused_sign = x[W-1];

    assign exp_ones  = &exp_field;
    assign exp_zero  = ~|exp_field;
    assign mant_zero = ~|mant_field;

    // NOTE: every field of cls gets a value on every pass, so no latch is inferred.
    always_comb begin
        cls        = '0;
        cls.nan    = exp_ones & ~mant_zero;
        cls.inf    = exp_ones &  mant_zero;
        cls.denorm = exp_zero & ~mant_zero;
        cls.zero   = exp_zero &  mant_zero;
    end

endmodule

// File: rtl/fp_special_cases.sv
// Special-case flags for two IEEE-754 operands. Combinational by default;
// define FP_SPECIAL_CASES_REG_EN to register all flags (1-cycle latency).
module fp_special_cases
    import fp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         a_is_nan,
    output logic         a_is_inf,
    output logic         a_is_denorm,
    output logic         a_is_zero,
    output logic         b_is_nan,
    output logic         b_is_inf,
    output logic         b_is_denorm,
    output logic         b_is_zero
);

    fp_class_t cls_a_d;
    fp_class_t cls_b_d;
    fp_class_t cls_a;
    fp_class_t cls_b;

    fp_classify_one #(.W(W)) u_class_a (
        .x   (in_a),
        .cls (cls_a_d)
    );

    fp_classify_one #(.W(W)) u_class_b (
        .x   (in_b),
        .cls (cls_b_d)
    );

`ifdef FP_SPECIAL_CASES_REG_EN
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cls_a <= '0;
            cls_b <= '0;
        end else begin
            cls_a <= cls_a_d;
            cls_b <= cls_b_d;
        end
    end
`else
    // Zero-latency path: compare units downstream rely on same-cycle flags.
    logic unused_clk_reset;

    assign unused_clk_reset = clk ^ reset;
    assign cls_a            = cls_a_d;
    assign cls_b            = cls_b_d;
`endif

    assign a_is_nan    = cls_a.nan;
    assign a_is_inf    = cls_a.inf;
    assign a_is_denorm = cls_a.denorm;
    assign a_is_zero   = cls_a.zero;

    assign b_is_nan    = cls_b.nan;
    assign b_is_inf    = cls_b.inf;
    assign b_is_denorm = cls_b.denorm;
    assign b_is_zero   = cls_b.zero;

endmodule

// File: tb/tb_fp_special_cases.sv
// Bench for fp_special_cases at W=32 and W=64; covers the registered build
// when FP_SPECIAL_CASES_REG_EN is defined. Flags packed {nan,inf,denorm,zero}.
module tb_fp_special_cases;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a32, b32;
    logic [63:0] a64, b64;
    logic        a32_nan, a32_inf, a32_den, a32_zero;
    logic        b32_nan, b32_inf, b32_den, b32_zero;
    logic        a64_nan, a64_inf, a64_den, a64_zero;
    logic        b64_nan, b64_inf, b64_den, b64_zero;
    logic [3:0]  fa32, fb32, fa64, fb64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_special_cases #(.W(32)) dut32 (
        .clk(clk), .reset(reset), .in_a(a32), .in_b(b32),
        .a_is_nan(a32_nan), .a_is_inf(a32_inf), .a_is_denorm(a32_den), .a_is_zero(a32_zero),
        .b_is_nan(b32_nan), .b_is_inf(b32_inf), .b_is_denorm(b32_den), .b_is_zero(b32_zero)
    );

    fp_special_cases #(.W(64)) dut64 (
        .clk(clk), .reset(reset), .in_a(a64), .in_b(b64),
        .a_is_nan(a64_nan), .a_is_inf(a64_inf), .a_is_denorm(a64_den), .a_is_zero(a64_zero),
        .b_is_nan(b64_nan), .b_is_inf(b64_inf), .b_is_denorm(b64_den), .b_is_zero(b64_zero)
    );

    assign fa32 = {a32_nan, a32_inf, a32_den, a32_zero};
    assign fb32 = {b32_nan, b32_inf, b32_den, b32_zero};
    assign fa64 = {a64_nan, a64_inf, a64_den, a64_zero};
    assign fb64 = {b64_nan, b64_inf, b64_den, b64_zero};

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] model32(input logic [31:0] x);
        logic [7:0]  e;
        logic [22:0] m;
        e = x[30:23];
        m = x[22:0];
        return {(e == 8'hFF) && (m != 0), (e == 8'hFF) && (m == 0),
                (e == 8'h00) && (m != 0), (e == 8'h00) && (m == 0)};
    endfunction

    function automatic logic [3:0] model64(input logic [63:0] x);
        logic [10:0] e;
        logic [51:0] m;
        e = x[62:52];
        m = x[51:0];
        return {(e == 11'h7FF) && (m != 0), (e == 11'h7FF) && (m == 0),
                (e == 11'h000) && (m != 0), (e == 11'h000) && (m == 0)};
    endfunction

    // Drive all four operands and wait until the flags are valid.
    task automatic apply(input logic [31:0] na32, input logic [31:0] nb32,
                         input logic [63:0] na64, input logic [63:0] nb64);
        @(negedge clk);
        a32 = na32; b32 = nb32; a64 = na64; b64 = nb64;
`ifdef FP_SPECIAL_CASES_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a32"}, fa32, model32(a32));
        check({tag, "_b32"}, fb32, model32(b32));
        check({tag, "_a64"}, fa64, model64(a64));
        check({tag, "_b64"}, fb64, model64(b64));
        check({tag, "_onehot"}, {3'b0, ($countones(fa32) <= 1) && ($countones(fb32) <= 1) &&
                                       ($countones(fa64) <= 1) && ($countones(fb64) <= 1)}, 4'b0001);
    endtask

    initial begin
        logic [7:0]  e32 [4];
        logic [22:0] m32 [3];
        logic [10:0] e64 [4];
        logic [51:0] m64 [3];
        e32 = '{8'h00, 8'h01, 8'hFE, 8'hFF};
        m32 = '{23'h0, 23'h1, 23'h7FFFFF};
        e64 = '{11'h000, 11'h001, 11'h7FE, 11'h7FF};
        m64 = '{52'h0, 52'h1, 52'hF_FFFF_FFFF_FFFF};

        reset = 1'b1;
        a32 = 32'h7F80_0000; b32 = 32'h7F80_0000;
        a64 = 64'h7FF0_0000_0000_0000; b64 = 64'h7FF0_0000_0000_0000;

`ifdef FP_SPECIAL_CASES_REG_EN
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_a32", fa32, 4'b0000);
        check("rst_hold_b64", fb64, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_before_edge", fa32, 4'b0000);
        @(posedge clk);
        #1;
        check("rel_after_edge", fa32, 4'b0100);
        check("rel_after_edge64", fa64, 4'b0100);
        @(negedge clk);
        a32 = 32'h0000_0000;
        #1;
        check("lat_old_value", fa32, 4'b0100);
        @(posedge clk);
        #1;
        check("lat_new_value", fa32, 4'b0001);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_a32", fa32, 4'b0000);
        check("async_rst_b32", fb32, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reload_a32", fa32, 4'b0001);
`else
        #1;
        check("comb_rst_ignored_a32", fa32, 4'b0100);
        check("comb_rst_ignored_a64", fa64, 4'b0100);
        reset = 1'b0;
        a32 = 32'h0000_0000;
        #1;
        check("comb_same_cycle", fa32, 4'b0001);
`endif

        // Directed vectors, expectations worked out by hand.
        apply(32'h7FC0_0000, 32'h7F80_0001, 64'h7FF0_0000_0000_0001, 64'hFFF0_0000_0000_0000);
        check("qnan_a32", fa32, 4'b1000);
        check("snan_b32", fb32, 4'b1000);
        check("nan_a64", fa64, 4'b1000);
        check("ninf_b64", fb64, 4'b0100);

        apply(32'hFF80_0000, 32'h8000_0000, 64'h000F_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        check("ninf_a32", fa32, 4'b0100);
        check("nzero_b32", fb32, 4'b0001);
        check("maxden_a64", fa64, 4'b0010);
        check("nzero_b64", fb64, 4'b0001);

        apply(32'h0000_0001, 32'h0000_0000, 64'h3FF0_0000_0000_0000, 64'h0010_0000_0000_0000);
        check("minden_a32", fa32, 4'b0010);
        check("pzero_b32", fb32, 4'b0001);
        check("one_a64", fa64, 4'b0000);
        check("minnorm_b64", fb64, 4'b0000);

        apply(32'h807F_FFFF, 32'h3F80_0000, 64'h7FF0_0000_0000_0000, 64'h0000_0000_0000_0001);
        check("nmaxden_a32", fa32, 4'b0010);
        check("one_b32", fb32, 4'b0000);
        check("pinf_a64", fa64, 4'b0100);
        check("minden_b64", fb64, 4'b0010);

        apply(32'h7F7F_FFFF, 32'h0080_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF);
        check("maxnorm_a32", fa32, 4'b0000);
        check("minnorm_b32", fb32, 4'b0000);
        check("allones_a64", fa64, 4'b1000);
        check("maxnorm_b64", fb64, 4'b0000);

        // Exponent/mantissa boundary patterns on A, random values on B.
        for (int s = 0; s < 2; s++) begin
            for (int ei = 0; ei < 4; ei++) begin
                for (int mi = 0; mi < 3; mi++) begin
                    apply({s[0], e32[ei], m32[mi]}, $urandom(),
                          {s[0], e64[ei], m64[mi]}, {$urandom(), $urandom()});
                    check_model("bound");
                end
            end
        end

        // Same boundary patterns on B so both operand paths see them.
        for (int ei = 0; ei < 4; ei++) begin
            for (int mi = 0; mi < 3; mi++) begin
                apply($urandom(), {1'b1, e32[ei], m32[mi]},
                      {$urandom(), $urandom()}, {1'b0, e64[ei], m64[mi]});
                check_model("bound_b");
            end
        end

        for (int i = 0; i < 40; i++) begin
            apply($urandom(), $urandom(), {$urandom(), $urandom()}, {$urandom(), $urandom()});
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_special_cases.md
Name: fp_special_cases

Overview:
- Classifies two IEEE-754 binary operands (single or double precision) into NaN, infinity, denormal and zero flags, one flag set per operand.
- Sits in front of the FPU compare and arithmetic units, which use the flags for special-case handling.
- Combinational by default. Output registering is selectable at compile time.

Parameters:
- W, 32, operand width. Legal values are only 32 (F=23, E=8) and 64 (F=52, E=11). Any other value is an elaboration error ($error in a generate check).

Ports:
- clk  input  1  clock; used only when the register feature is enabled
- reset  input  1  asynchronous, active-high reset; used only when the register feature is enabled
- in_a  input  W  operand A, raw IEEE bits
- in_b  input  W  operand B, raw IEEE bits
- a_is_nan  output  1  A is NaN (quiet or signalling)
- a_is_inf  output  1  A is +/- infinity
- a_is_denorm  output  1  A is subnormal
- a_is_zero  output  1  A is +0 or -0
- b_is_nan, b_is_inf, b_is_denorm, b_is_zero  output  1 each  same definitions for B

Behaviour:
- Field split per operand: sign = x[W-1], exp = x[W-2:F], mant = x[F-1:0].
- nan = (exp == all ones) && (mant != 0).
- inf = (exp == all ones) && (mant == 0).
- denorm = (exp == 0) && (mant != 0).
- zero = (exp == 0) && (mant == 0).
- The sign bit is ignored by all four flags.
- At most one flag per operand is 1. All four are 0 for normal numbers.
- The A and B classifications are fully independent. Identical inputs give identical flags.
- No NaN payload or quiet/signalling distinction is reported.
- Default (feature off):
  - Pure combinational path, zero latency.
  - clk and reset are unused; no state.
  - Outputs follow the inputs in the same cycle.
- With the feature on: see Optional Feature.
- X on an input bit propagates X only to the flags of that operand.

Optional Feature:
- Macro FP_SPECIAL_CASES_REG_EN.
- Defined:
  - All eight flags are registered on posedge clk, giving 1-cycle latency from in_a/in_b.
  - reset asserted asynchronously forces all eight flags to 0 immediately, and they stay 0 while reset is high.
  - On the first posedge after reset deasserts, the flags capture the classification of the inputs present at that edge.
  - A reset asserted mid-stream discards the pending value; the registers reload normally after release.
- Undefined:
  - Combinational as in Behaviour; clk and reset are ignored.
  - Consumers such as fp_compare depend on this zero-latency mode.

Decomposition:
- Shared package fp_pkg holds:
  - localparams or functions fp_frac_bits(W) and fp_exp_bits(W), returning 23/8 for 32 and 52/11 for 64.
  - Packed struct fp_class_t {nan, inf, denorm, zero}.
- One natural sub-module, fp_classify_one #(W): input x [W-1:0], output fp_class_t.
- fp_classify_one is instantiated twice (A, B). The top adds the optional register stage and unpacks the structs onto the ports.

Test Plan:
- W=32, combinational:
  - in_a=0x7FC00000 -> a_is_nan=1, other A flags 0.
  - in_b=0x7F800001 -> b_is_nan=1.
- W=32, infinities and zeros:
  - in_a=0xFF800000 -> a_is_inf=1.
  - in_b=0x80000000 -> b_is_zero=1; in_b=0x00000000 also gives b_is_zero=1.
- W=32, denormal and normal:
  - in_a=0x00000001 -> a_is_denorm=1.
  - in_a=0x807FFFFF -> a_is_denorm=1.
  - in_b=0x3F800000 -> all B flags 0.
  - in_b=0x00800000 (smallest normal) -> all 0.
- W=64:
  - in_a=0x7FF0000000000001 -> a_is_nan=1.
  - in_b=0xFFF0000000000000 -> b_is_inf=1.
  - in_a=0x000FFFFFFFFFFFFF -> a_is_denorm=1.
  - in_b=0x8000000000000000 -> b_is_zero=1.
- FP_SPECIAL_CASES_REG_EN, W=32:
  - Hold reset=1 with in_a=0x7F800000 -> all flags 0.
  - Release reset -> a_is_inf=1 after the next posedge, not before.
  - Change in_a to 0x00000000 -> a_is_zero=1 one cycle later.
  - Assert reset asynchronously between edges -> flags drop to 0 immediately.
- Independence sweep, both modes: drive random W-bit pairs plus all exp-boundary patterns (exp = 0, 1, max-1, max; mant = 0, 1, max).
  - Compare against the bit-level equations above.
  - Check exactly one flag or none set per operand.
